// File: rtl/truth_table_reader.sv
// truth_table_reader: drives all 16 input vectors into a 4-input function, captures its truth table and compares it against a golden mask
module truth_table_reader #(
  parameter int SETTLE = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_expected,
  input  logic        i_s,
  output logic        o_x,
  output logic        o_y,
  output logic        o_w,
  output logic        o_z,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_table,
  output logic        o_mismatch,
  output logic [3:0]  o_first_err,
  output logic [4:0]  o_err_count
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [2:0] SETTLE_C = 3'(SETTLE);
  logic [0:0]  r_state;
  logic [3:0]  r_idx;
  logic [2:0]  r_cnt;
  logic        r_done;
  logic [15:0] r_exp;
  logic [15:0] r_table;
  logic        r_mis;
  logic [3:0]  r_first;
  logic [4:0]  r_errc;
  logic        w_accept;
  logic        w_sample;
  logic        w_bad;
  logic        w_last;
  assign w_accept = (r_state == IDLE) && i_start;
  assign w_sample = (r_state == RUN) && (r_cnt == SETTLE_C);
  assign w_bad    = i_s != r_exp[r_idx];
  assign w_last   = r_idx == 4'hF;
  assign {o_x, o_y, o_w, o_z} = r_idx;
  assign o_busy      = r_state == RUN;
  assign o_done      = r_done;
  assign o_table     = r_table;
  assign o_mismatch  = r_mis;
  assign o_first_err = r_first;
  assign o_err_count = r_errc;
  // sequencing: accept start in IDLE, hold each vector SETTLE+1 cycles, pulse done after vector 15
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
      r_cnt   <= 3'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_sample && w_last;
      if (w_accept) begin
        r_state <= RUN;
        r_idx   <= 4'd0;
        r_cnt   <= 3'd0;
      end else if (w_sample) begin
        r_state <= w_last ? IDLE : RUN;
        r_idx   <= r_idx + 4'd1;
        r_cnt   <= 3'd0;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end
  // capture: latch golden mask on start, record each response and keep the mismatch summary
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_exp   <= 16'd0;
      r_table <= 16'd0;
      r_mis   <= 1'b0;
      r_first <= 4'd0;
      r_errc  <= 5'd0;
    end else if (w_accept) begin
      r_exp   <= i_expected;
      r_table <= 16'd0;
      r_mis   <= 1'b0;
      r_first <= 4'd0;
      r_errc  <= 5'd0;
    end else if (w_sample) begin
      r_table[r_idx] <= i_s;
      if (w_bad) begin
        r_errc <= r_errc + 5'd1;
        if (!r_mis) begin
          r_mis   <= 1'b1;
          r_first <= r_idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_truth_table_reader.sv
// tb_truth_table_reader: random and directed sweeps on SETTLE=1 and SETTLE=3 instances against a truth-table model
module tb_truth_table_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, start;
  logic [15:0] expv, tt;
  logic        x1, y1, w1, z1, s1, busy1, done1, mis1;
  logic [15:0] tab1;
  logic [3:0]  fe1;
  logic [4:0]  ec1;
  logic        x3, y3, w3, z3, s3, busy3, done3, mis3;
  logic [15:0] tab3;
  logic [3:0]  fe3;
  logic [4:0]  ec3;
  int total = 0;
  int bad = 0;
  localparam logic [15:0] SOP = 16'h41C5;
  assign s1 = tt[{x1, y1, w1, z1}];
  assign s3 = tt[{x3, y3, w3, z3}];
  truth_table_reader #(.SETTLE(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_expected(expv), .i_s(s1),
    .o_x(x1), .o_y(y1), .o_w(w1), .o_z(z1), .o_busy(busy1), .o_done(done1),
    .o_table(tab1), .o_mismatch(mis1), .o_first_err(fe1), .o_err_count(ec1)
  );
  truth_table_reader #(.SETTLE(3)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_expected(expv), .i_s(s3),
    .o_x(x3), .o_y(y3), .o_w(w3), .o_z(z3), .o_busy(busy3), .o_done(done3),
    .o_table(tab3), .o_mismatch(mis3), .o_first_err(fe3), .o_err_count(ec3)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  function automatic void model(input logic [15:0] t, input logic [15:0] e,
                                output logic [4:0] cnt, output logic [3:0] fe, output logic m);
    cnt = 0;
    fe = 0;
    m = 0;
    for (int v = 15; v >= 0; v--)
      if (t[v] !== e[v]) begin
        cnt++;
        fe = v[3:0];
        m = 1;
      end
  endfunction
  task automatic chk_idle_zero(input string tag);
    chk({tag, " busy1"}, busy1, 0);
    chk({tag, " done1"}, done1, 0);
    chk({tag, " vec1"}, {x1, y1, w1, z1}, 0);
    chk({tag, " tab1"}, tab1, 0);
    chk({tag, " res1"}, {mis1, fe1, ec1}, 0);
    chk({tag, " busy3"}, busy3, 0);
    chk({tag, " done3"}, done3, 0);
    chk({tag, " vec3"}, {x3, y3, w3, z3}, 0);
    chk({tag, " tab3"}, tab3, 0);
    chk({tag, " res3"}, {mis3, fe3, ec3}, 0);
  endtask
  task automatic sweep(input logic [15:0] t, input logic [15:0] e, input bit repulse);
    logic [4:0] mc;
    logic [3:0] mf;
    logic       mm;
    tt = t;
    expv = e;
    @(negedge clk) start = 1;
    @(posedge clk);
    @(negedge clk) start = 0;
    for (int k = 0; k <= 66; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 5) expv = $urandom;
      if (repulse) start = (k == 10);
      if (k == 0) chk("cleared1", {tab1, mis1, fe1, ec1}, 0);
      chk("busy1", busy1, k < 32);
      chk("done1", done1, k == 32);
      chk("vec1", {x1, y1, w1, z1}, (k < 32) ? k / 2 : 0);
      chk("busy3", busy3, k < 64);
      chk("done3", done3, k == 64);
      chk("vec3", {x3, y3, w3, z3}, (k < 64) ? k / 4 : 0);
    end
    start = 0;
    model(t, e, mc, mf, mm);
    chk("table1", tab1, t);
    chk("mis1", mis1, mm);
    chk("first1", fe1, mf);
    chk("cnt1", ec1, mc);
    chk("table3", tab3, t);
    chk("mis3", mis3, mm);
    chk("first3", fe3, mf);
    chk("cnt3", ec3, mc);
  endtask
  initial begin
    logic [15:0] rt, re;
    rst = 1;
    start = 0;
    expv = 0;
    tt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) chk_idle_zero("reset");
    rst = 0;
    sweep(SOP, 16'h41C5, 0);
    sweep(SOP, 16'h41C4, 0);
    sweep(16'hFFFF, 16'h0000, 0);
    sweep(SOP, 16'h41C5, 1);
    sweep(16'h0000, 16'h0000, 0);
    for (int n = 0; n < 6; n++) begin
      rt = $urandom;
      re = (n % 2) ? $urandom : rt ^ (16'h8000 >> $urandom_range(0, 15));
      sweep(rt, re, 0);
    end
    tt = SOP;
    expv = 16'h1234;
    @(negedge clk) start = 1;
    @(posedge clk);
    @(negedge clk) start = 0;
    repeat (14) @(negedge clk);
    chk("abort vec1", {x1, y1, w1, z1}, 7);
    rst = 1;
    @(negedge clk) rst = 0;
    chk_idle_zero("abort");
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      chk("abort nodone", {done1, done3, busy1, busy3}, 0);
    end
    sweep(SOP, 16'h41C5, 0);
    tt = 16'hA5A5;
    expv = 16'h5A5A;
    @(negedge clk) start = 1;
    @(posedge clk);
    for (int k = 0; k <= 34; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      chk("hold busy1", busy1, k != 32);
      chk("hold done1", done1, k == 32);
      if (k == 32) chk("hold final1", {tab1, ec1}, {16'hA5A5, 5'd16});
      if (k == 33) chk("hold restart1", {x1, y1, w1, z1, tab1, mis1, ec1}, 0);
      chk("hold busy3", busy3, 1);
    end
    rst = 1;
    start = 0;
    @(negedge clk) rst = 0;
    chk_idle_zero("final reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/truth_table_reader.md
TRUTH_TABLE_READER -- requirements
Module: truth_table_reader

Interface
REQ-001 Parameter SETTLE, default 1, is the number of extra cycles each input vector is held before the response is sampled; legal range 0..7.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to sweep all 16 input vectors; honoured only in IDLE.
REQ-005 expected  input  16  golden minterm mask; bit i = required s for vector i.
REQ-006 x, y, w, z  output  1 each  vector driven to the function under test; {x,y,w,z} = vector index, x MSB.
REQ-007 s  input  1  combinational response of the function under test.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse at sweep completion.
REQ-010 table  output  16  captured truth table; bit i = s sampled for vector i.
REQ-011 mismatch  output  1  high if any table bit differs from the latched expected bit.
REQ-012 first_err  output  4  lowest vector index that mismatched; 0 when mismatch=0.
REQ-013 err_count  output  5  number of mismatching vectors, 0..16.

Function
REQ-014 The FSM SHALL have states IDLE and RUN; DONE is a registered pulse, not a state.
REQ-015 In IDLE, start=1 at an edge SHALL move to RUN at that edge: busy=1, index=0, settle counter=0, expected latched, and table, mismatch, first_err, err_count cleared.
REQ-016 x, y, w, z SHALL be registered outputs equal to the current index and SHALL change only at vector advance.
REQ-017 In RUN, the settle counter SHALL increment each cycle; at the edge where it equals SETTLE, table[index] <= s, the comparison is made, index increments, and the counter returns to 0.
REQ-018 Each vector SHALL therefore be held SETTLE+1 cycles; a full sweep SHALL take 16*(SETTLE+1) cycles from the start edge.
REQ-019 On mismatch at index i: err_count increments; if mismatch was 0, first_err <= i and mismatch <= 1; first_err SHALL NOT change afterwards.
REQ-020 At the edge sampling index 15, the FSM SHALL return to IDLE: busy=0, done=1 for exactly one cycle, and index wraps to 0 (x,y,w,z = 0).
REQ-021 start while busy=1 SHALL be ignored; start held high in IDLE SHALL begin a new sweep on every IDLE edge, including the cycle done is high.
REQ-022 table, mismatch, first_err, err_count SHALL hold their final values in IDLE until the next accepted start or reset.
REQ-023 Changes on expected during RUN SHALL have no effect.
REQ-024 err_count SHALL be 5 bits wide so that 16 mismatches are represented without wrap.

Reset
REQ-025 reset=1 at an edge SHALL, with priority over start, force IDLE and set busy=0, done=0, x=y=w=z=0, table=0, mismatch=0, first_err=0, err_count=0, and clear the index and counter.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; the first start after reset SHALL run a full 16-vector sweep.

Verification
REQ-027 SETTLE=1, s driven by the team's SoP function (minterms 0,2,6,7,8,14), expected=16'h41C5, start pulse -> done exactly 32 cycles after the start edge, table=16'h41C5, mismatch=0, err_count=0, first_err=0.
REQ-028 Same function, expected=16'h41C4 -> table=16'h41C5, mismatch=1, first_err=0, err_count=1.
REQ-029 s tied 1, expected=16'h0000 -> table=16'hFFFF, mismatch=1, first_err=0, err_count=16.
REQ-030 start re-pulsed at cycle 10 of a sweep -> ignored; exactly one done pulse at cycle 32; x,y,w,z step 0..15 monotonically.
REQ-031 reset asserted while index=7 -> next cycle all outputs at reset values and no done; a later start gives a full, correct sweep.
REQ-032 SETTLE=3, s tied 0, expected=16'h0000 -> each vector held 4 cycles, done at cycle 64, table=0, mismatch=0.
